// File: rtl/vproc_pkg.sv
// Shared vector-processor types, plus the ELEM beat-sequencer state enum and helpers.
package vproc_pkg;

    typedef enum logic [3:0] {
        ELEM_XMV       = 4'd0,
        ELEM_VPOPC     = 4'd1,
        ELEM_VFIRST    = 4'd2,
        ELEM_VID       = 4'd3,
        ELEM_VIOTA     = 4'd4,
        ELEM_VRGATHER  = 4'd5,
        ELEM_VCOMPRESS = 4'd6,
        ELEM_FLUSH     = 4'd7,
        ELEM_VREDSUM   = 4'd8,
        ELEM_VREDAND   = 4'd9,
        ELEM_VREDOR    = 4'd10,
        ELEM_VREDXOR   = 4'd11,
        ELEM_VREDMINU  = 4'd12,
        ELEM_VREDMIN   = 4'd13,
        ELEM_VREDMAXU  = 4'd14,
        ELEM_VREDMAX   = 4'd15
    } op_elem;

    typedef enum logic [1:0] {
        VSEW_8       = 2'd0,
        VSEW_16      = 2'd1,
        VSEW_32      = 2'd2,
        VSEW_INVALID = 2'd3
    } cfg_vsew;

    typedef enum logic [1:0] {
        EMUL_1 = 2'd0,
        EMUL_2 = 2'd1,
        EMUL_4 = 2'd2,
        EMUL_8 = 2'd3
    } cfg_emul;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAIN  = 2'd1,
        FLUSH = 2'd2
    } elem_seq_state_t;

    // Elements per register group for a given element width and group multiplier.
    function automatic int unsigned vlmax(input cfg_vsew eew, input cfg_emul emul,
                                          input int unsigned vreg_w);
        return ((vreg_w / 8) >> eew) << emul;
    endfunction

    function automatic logic is_reduction(input op_elem op);
        return op inside {ELEM_VREDSUM, ELEM_VREDAND, ELEM_VREDOR, ELEM_VREDXOR,
                          ELEM_VREDMINU, ELEM_VREDMIN, ELEM_VREDMAXU, ELEM_VREDMAX};
    endfunction

endpackage

// File: rtl/vproc_elem_seq_cnt.sv
// Up-counter with clear, enable and a terminal-count flag; wraps to zero when
// enabled at the terminal count.
module vproc_elem_seq_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         sync_rst_i,
    input  logic         clear_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_c_o
);

    logic [W-1:0] cnt_q;

    assign tc_c_o = (cnt_q == term_i);
    assign cnt_o  = cnt_q;

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= tc_c_o ? '0 : cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/vproc_elem_seq.sv
// Beat sequencer for the vector ELEM unit: expands one instruction into main and flush beats.
// Optional feature: VPROC_ELEM_SEQ_TAIL_SKIP_EN stops reductions/vpopc/vfirst at the vl boundary.
module vproc_elem_seq
    import vproc_pkg::*;
#(
    parameter int unsigned VREG_W         = 128,
    parameter int unsigned GATHER_OP_W    = 32,
    parameter bit          DONT_CARE_ZERO = 1'b0
) (
    input  logic                                    clk_i,
    input  logic                                    sync_rst_i,
    input  logic                                    instr_valid_i,
    output logic                                    instr_ready_o,
    input  op_elem                                  instr_op_i,
    input  cfg_vsew                                 instr_eew_i,
    input  cfg_emul                                 instr_emul_i,
    input  logic [$clog2(VREG_W):0]                 instr_vl_i,
    input  logic                                    instr_masked_i,
    input  logic                                    instr_xreg_i,
    input  logic [4:0]                              instr_vaddr_i,
    output logic                                    seq_valid_o,
    input  logic                                    seq_ready_i,
    output op_elem                                  seq_op_o,
    output cfg_vsew                                 seq_eew_o,
    output cfg_emul                                 seq_emul_o,
    output logic                                    seq_masked_o,
    output logic                                    seq_xreg_o,
    output logic [4:0]                              seq_vaddr_o,
    output logic [$clog2(VREG_W)-1:0]               seq_elem_idx_o,
    output logic [$clog2(VREG_W/GATHER_OP_W)-1:0]   seq_aux_count_o,
    output logic                                    seq_first_cycle_o,
    output logic                                    seq_last_cycle_o,
    output logic                                    seq_vl_part_0_o,
    output logic                                    seq_vl_0_o,
    output logic                                    seq_end_o,
    output logic                                    busy_o
);

    localparam int unsigned IDX_W = $clog2(VREG_W);
    localparam int unsigned VL_W  = IDX_W + 1;
    localparam int unsigned AUX_W = $clog2(VREG_W / GATHER_OP_W);
    localparam int unsigned FL_W  = $clog2((VREG_W / 32) * 8);

    elem_seq_state_t state_q, state_d;

    op_elem           op_q;
    cfg_vsew          eew_q;
    cfg_emul          emul_q;
    logic             masked_q;
    logic             xreg_q;
    logic [4:0]       vaddr_q;
    logic [VL_W-1:0]  vl_q;
    logic [IDX_W-1:0] idx_term_q, idx_term_d;
    logic [AUX_W-1:0] aux_term_q, aux_term_d;
    logic [FL_W-1:0]  flush_term_q, flush_term_d;
    logic             has_flush_q, has_flush_d;

    logic [VL_W-1:0]  vlmax_c;
    logic             accept_c;
    logic             beat_hs_c;
    logic             main_last_c;
    logic             aux_en_c, idx_en_c, flush_en_c;

    logic [IDX_W-1:0] idx_cnt;
    logic [AUX_W-1:0] aux_cnt;
    logic [FL_W-1:0]  flush_cnt;
    logic             idx_tc_c, aux_tc_c, flush_tc_c;

    // Terminal counts for the offered instruction, latched on acceptance.
    assign vlmax_c = VL_W'(vlmax(instr_eew_i, instr_emul_i, VREG_W));

    always_comb begin
        idx_term_d   = IDX_W'(vlmax_c - VL_W'(1));
        aux_term_d   = '0;
        flush_term_d = '0;
        has_flush_d  = 1'b0;
        if (instr_op_i == ELEM_XMV) begin
            idx_term_d = '0;
        end
        if (instr_op_i == ELEM_VRGATHER) begin
            aux_term_d = '1;
        end
`ifdef VPROC_ELEM_SEQ_TAIL_SKIP_EN
        if (is_reduction(instr_op_i) || (instr_op_i == ELEM_VPOPC) ||
            (instr_op_i == ELEM_VFIRST)) begin
            idx_term_d = (instr_vl_i == '0) ? '0 : IDX_W'(instr_vl_i - VL_W'(1));
        end
`endif
        if (instr_op_i == ELEM_VCOMPRESS) begin
            has_flush_d  = 1'b1;
            flush_term_d = FL_W'(((VREG_W / 32) << instr_emul_i) - 1);
        end else if (is_reduction(instr_op_i)) begin
            has_flush_d  = 1'b1;
            flush_term_d = FL_W'((VREG_W / 32) - 2);
        end
    end

    assign beat_hs_c   = seq_valid_o & seq_ready_i;
    assign main_last_c = idx_tc_c & aux_tc_c;
    assign aux_en_c    = beat_hs_c & (state_q == MAIN);
    assign idx_en_c    = aux_en_c & aux_tc_c;
    assign flush_en_c  = beat_hs_c & (state_q == FLUSH);

    // Next-state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        accept_c      = 1'b0;
        instr_ready_o = 1'b0;
        seq_valid_o   = 1'b0;
        busy_o        = 1'b0;
        case (state_q)
            IDLE: begin
                instr_ready_o = ~sync_rst_i;
                if (instr_valid_i && !sync_rst_i) begin
                    accept_c = 1'b1;
                    state_d  = MAIN;
                end
            end
            MAIN: begin
                seq_valid_o = 1'b1;
                busy_o      = 1'b1;
                if (beat_hs_c && main_last_c) begin
                    state_d = has_flush_q ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                seq_valid_o = 1'b1;
                busy_o      = 1'b1;
                if (beat_hs_c && flush_tc_c) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            op_q         <= ELEM_XMV;
            eew_q        <= VSEW_8;
            emul_q       <= EMUL_1;
            masked_q     <= 1'b0;
            xreg_q       <= 1'b0;
            vaddr_q      <= '0;
            vl_q         <= '0;
            idx_term_q   <= '0;
            aux_term_q   <= '0;
            flush_term_q <= '0;
            has_flush_q  <= 1'b0;
        end else if (accept_c) begin
            op_q         <= instr_op_i;
            eew_q        <= instr_eew_i;
            emul_q       <= instr_emul_i;
            masked_q     <= instr_masked_i;
            xreg_q       <= instr_xreg_i;
            vaddr_q      <= instr_vaddr_i;
            vl_q         <= instr_vl_i;
            idx_term_q   <= idx_term_d;
            aux_term_q   <= aux_term_d;
            flush_term_q <= flush_term_d;
            has_flush_q  <= has_flush_d;
        end
    end

    vproc_elem_seq_cnt #(.W(IDX_W)) u_idx_cnt (
        .clk_i      (clk_i),
        .sync_rst_i (sync_rst_i),
        .clear_i    (accept_c),
        .en_i       (idx_en_c),
        .term_i     (idx_term_q),
        .cnt_o      (idx_cnt),
        .tc_c_o     (idx_tc_c)
    );

    vproc_elem_seq_cnt #(.W(AUX_W)) u_aux_cnt (
        .clk_i      (clk_i),
        .sync_rst_i (sync_rst_i),
        .clear_i    (accept_c),
        .en_i       (aux_en_c),
        .term_i     (aux_term_q),
        .cnt_o      (aux_cnt),
        .tc_c_o     (aux_tc_c)
    );

    vproc_elem_seq_cnt #(.W(FL_W)) u_flush_cnt (
        .clk_i      (clk_i),
        .sync_rst_i (sync_rst_i),
        .clear_i    (accept_c),
        .en_i       (flush_en_c),
        .term_i     (flush_term_q),
        .cnt_o      (flush_cnt),
        .tc_c_o     (flush_tc_c)
    );

    // Beat control word; index and flags read zero outside the phase they describe.
    always_comb begin
        seq_elem_idx_o    = '0;
        seq_aux_count_o   = '0;
        seq_first_cycle_o = 1'b0;
        seq_last_cycle_o  = 1'b0;
        seq_vl_part_0_o   = 1'b0;
        seq_vl_0_o        = 1'b0;
        seq_end_o         = 1'b0;
        if (state_q == MAIN) begin
            seq_elem_idx_o    = idx_cnt;
            seq_aux_count_o   = aux_cnt;
            seq_first_cycle_o = (idx_cnt == '0) && (aux_cnt == '0);
            seq_last_cycle_o  = main_last_c;
            seq_vl_part_0_o   = ({1'b0, idx_cnt} >= vl_q);
            seq_vl_0_o        = (vl_q == '0);
            seq_end_o         = main_last_c & ~has_flush_q;
        end else if (state_q == FLUSH) begin
            seq_vl_part_0_o   = 1'b1;
            seq_vl_0_o        = (vl_q == '0);
            seq_end_o         = flush_tc_c;
        end
    end

    // Latched instruction fields; undefined while no beat is offered.
    always_comb begin
        seq_op_o     = DONT_CARE_ZERO ? op_elem'('0)  : op_elem'('x);
        seq_eew_o    = DONT_CARE_ZERO ? cfg_vsew'('0) : cfg_vsew'('x);
        seq_emul_o   = DONT_CARE_ZERO ? cfg_emul'('0) : cfg_emul'('x);
        seq_masked_o = DONT_CARE_ZERO ? 1'b0 : 1'bx;
        seq_xreg_o   = DONT_CARE_ZERO ? 1'b0 : 1'bx;
        seq_vaddr_o  = DONT_CARE_ZERO ? 5'd0 : 5'bx;
        if (state_q != IDLE) begin
            seq_op_o     = (state_q == FLUSH) ? ELEM_FLUSH : op_q;
            seq_eew_o    = eew_q;
            seq_emul_o   = emul_q;
            seq_masked_o = masked_q;
            seq_xreg_o   = xreg_q;
            seq_vaddr_o  = vaddr_q;
        end
    end

endmodule
